// File: rtl/index_writeback.sv
// Write side of the MIX index registers I1..I6: ENT/ENN/INC/DEC/LD/LDN with a
// fixed two-cycle writeback after the handshake, sign-magnitude arithmetic.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command to latch
// EXEC  | read selected register, compute result and flags
// WB    | write result (unless err), pulse done/ovf/err on next cycle
module index_writeback #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [2:0]   cmd_sel,
  input  logic [W-1:0] cmd_m,
  input  logic [W-1:0] cmd_data,
  output logic         done,
  output logic         ovf,
  output logic         err,
  output logic [W-1:0] i1,
  output logic [W-1:0] i2,
  output logic [W-1:0] i3,
  output logic [W-1:0] i4,
  output logic [W-1:0] i5,
  output logic [W-1:0] i6
);

  localparam int MW = W - 1;

  localparam logic [2:0] OP_ENT = 3'd0;
  localparam logic [2:0] OP_ENN = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_LDN = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t         state;
  logic [2:0]     op_q, sel_q;
  logic [W-1:0]   m_q, data_q, res_q;
  logic           ovf_q, err_q;
  logic [W-1:0]   ireg [1:6];

  logic [W-1:0]   opnd, nxt_res;
  logic           nxt_ovf, nxt_err;
  logic           sa, sb;
  logic [MW-1:0]  ma, mb;
  logic [MW:0]    sum;

  always_comb begin
    opnd = '0;
    case (sel_q)
      3'd1: opnd = ireg[1];
      3'd2: opnd = ireg[2];
      3'd3: opnd = ireg[3];
      3'd4: opnd = ireg[4];
      3'd5: opnd = ireg[5];
      3'd6: opnd = ireg[6];
      default: opnd = '0;
    endcase

    sa  = opnd[W-1];
    ma  = opnd[MW-1:0];
    sb  = m_q[W-1] ^ (op_q == OP_DEC);
    mb  = m_q[MW-1:0];
    sum = {1'b0, ma} + {1'b0, mb};

    nxt_err = (op_q > OP_LDN) || (sel_q == 3'd0) || (sel_q == 3'd7);
    nxt_ovf = 1'b0;
    nxt_res = opnd;

    case (op_q)
      OP_ENT: nxt_res = m_q;
      OP_ENN: nxt_res = {~m_q[W-1], m_q[MW-1:0]};
      OP_LD:  nxt_res = data_q;
      OP_LDN: nxt_res = {~data_q[W-1], data_q[MW-1:0]};
      OP_INC, OP_DEC: begin
        if (sa == sb) begin
          nxt_res = {sa, sum[MW-1:0]};
          nxt_ovf = sum[MW];
        end else if (ma > mb) begin
          nxt_res = {sa, ma - mb};
        end else if (mb > ma) begin
          nxt_res = {sb, mb - ma};
        end else begin
          nxt_res = {sa, {MW{1'b0}}};
        end
      end
      default: nxt_res = opnd;
    endcase

    if (nxt_err) nxt_ovf = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      op_q      <= '0;
      sel_q     <= '0;
      m_q       <= '0;
      data_q    <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 1; k <= 6; k++) ireg[k] <= '0;
    end else begin
      done <= 1'b0;
      ovf  <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            sel_q     <= cmd_sel;
            m_q       <= cmd_m;
            data_q    <= cmd_data;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          res_q <= nxt_res;
          ovf_q <= nxt_ovf;
          err_q <= nxt_err;
          state <= WB;
        end
        WB: begin
          for (int k = 1; k <= 6; k++)
            if (!err_q && sel_q == 3'(k)) ireg[k] <= res_q;
          done      <= 1'b1;
          ovf       <= ovf_q;
          err       <= err_q;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign i1 = ireg[1];
  assign i2 = ireg[2];
  assign i3 = ireg[3];
  assign i4 = ireg[4];
  assign i5 = ireg[5];
  assign i6 = ireg[6];

endmodule

// File: tb/tb_index_writeback.sv
// Randomized + directed bench for index_writeback against an integer-arithmetic
// model of the index registers.
module tb_index_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_sel;
  logic [12:0] cmd_m;
  logic [12:0] cmd_data;
  logic        done, ovf, err;
  logic [12:0] i1, i2, i3, i4, i5, i6;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] mdl [1:6];
  logic [12:0] iv  [1:6];

  assign iv[1] = i1;
  assign iv[2] = i2;
  assign iv[3] = i3;
  assign iv[4] = i4;
  assign iv[5] = i5;
  assign iv[6] = i6;

  index_writeback #(.W(13)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_m(cmd_m), .cmd_data(cmd_data),
    .done(done), .ovf(ovf), .err(err),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sm_to_int(input logic [12:0] x);
    return x[12] ? -int'(x[11:0]) : int'(x[11:0]);
  endfunction

  // Expected result computed from signed integer arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [2:0] sel,
                       input logic [12:0] m, input logic [12:0] d,
                       output logic [12:0] r, output logic e, output logic o);
    logic [12:0] cur;
    int vi, vm, s, a;
    e = (op > 3'd5) || (sel == 3'd0) || (sel == 3'd7);
    o = 1'b0;
    cur = (sel >= 3'd1 && sel <= 3'd6) ? mdl[sel] : 13'h0000;
    r = cur;
    if (!e) begin
      case (op)
        3'd0: r = m;
        3'd1: r = m ^ 13'h1000;
        3'd4: r = d;
        3'd5: r = d ^ 13'h1000;
        default: begin
          vi = sm_to_int(cur);
          vm = sm_to_int(m);
          if (op == 3'd3) vm = -vm;
          s = vi + vm;
          a = (s < 0) ? -s : s;
          o = (a > 4095);
          r[11:0] = 12'(a % 4096);
          r[12] = (s > 0) ? 1'b0 : (s < 0) ? 1'b1 : cur[12];
        end
      endcase
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 1; k <= 6; k++)
      check($sformatf("%s_i%0d", tag, k), 32'(iv[k]), 32'(mdl[k]));
  endtask

  // Issue one command; entered and left at posedge+1.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] sel,
                        input logic [12:0] m, input logic [12:0] d, input bit hold);
    logic [12:0] r;
    logic e, o;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_sel = sel; cmd_m = m; cmd_data = d;
    check("ready_before", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    model(op, sel, m, d, r, e, o);
    if (!hold) begin
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op = 3'($urandom); cmd_sel = 3'($urandom);
      cmd_m = 13'($urandom); cmd_data = 13'($urandom);
    end
    check("exec_ready", 32'(cmd_ready), 32'd0);
    check("exec_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("wb_ready", 32'(cmd_ready), 32'd0);
    check("wb_done", 32'(done), 32'd0);
    check_regs("wb_hold");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!e) mdl[sel] = r;
    check("done", 32'(done), 32'd1);
    check("ovf", 32'(ovf), 32'(o));
    check("err", 32'(err), 32'(e));
    check("ret_ready", 32'(cmd_ready), 32'd1);
    check_regs("ret");
    @(posedge clk); #1;
    check("post_done", 32'(done), 32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) mdl[k] = 13'h0000;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_regs("rst");
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] op, sel;
    logic [12:0] m;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_sel = '0; cmd_m = '0; cmd_data = '0;
    apply_reset();

    do_cmd(3'd0, 3'd3, 13'h0064, 13'h0000, 1'b0);
    do_cmd(3'd0, 3'd2, 13'd4000, 13'h0000, 1'b0);
    do_cmd(3'd2, 3'd2, 13'd200, 13'h0000, 1'b0);
    check("inc_wrap_i2", 32'(i2), 32'h0068);
    do_cmd(3'd0, 3'd5, 13'd5, 13'h0000, 1'b0);
    do_cmd(3'd3, 3'd5, 13'd7, 13'h0000, 1'b0);
    check("dec_i5", 32'(i5), 32'h1002);
    do_cmd(3'd2, 3'd5, 13'd2, 13'h0000, 1'b0);
    check("neg_zero_i5", 32'(i5), 32'h1000);
    do_cmd(3'd1, 3'd1, 13'h0000, 13'h0000, 1'b0);
    check("enn_i1", 32'(i1), 32'h1000);
    do_cmd(3'd5, 3'd6, 13'h0000, 13'h1ABC, 1'b0);
    check("ldn_i6", 32'(i6), 32'h0ABC);
    do_cmd(3'd6, 3'd4, 13'h0123, 13'h0456, 1'b1);
    do_cmd(3'd0, 3'd0, 13'd9, 13'h0000, 1'b1);
    do_cmd(3'd0, 3'd7, 13'd9, 13'h0000, 1'b0);

    // Reset while a command is in EXEC: it must vanish without done.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_sel = 3'd1; cmd_m = 13'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_exec_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) mdl[k] = 13'h0000;
    check("rst_exec_ready", 32'(cmd_ready), 32'd1);
    check_regs("rst_exec");
    @(posedge clk); #1;
    check("rst_exec_done2", 32'(done), 32'd0);
    check("rst_exec_ready2", 32'(cmd_ready), 32'd1);
    check_regs("rst_exec2");

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      sel = ($urandom_range(0, 11) == 0) ? ($urandom_range(0, 1) == 1 ? 3'd7 : 3'd0)
                                         : 3'($urandom_range(1, 6));
      m = 13'($urandom);
      if ($urandom_range(0, 3) == 0) m[11:0] = 12'($urandom_range(3900, 4095));
      if ($urandom_range(0, 7) == 0) m[11:0] = 12'd0;
      do_cmd(op, sel, m, 13'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
